// File: rtl/polar_pkg.sv
// Shared types and min-sum arithmetic for the polar SC decoder.
// Arithmetic runs on a wide signed type and is saturated back to the LLR range by callers.
package polar_pkg;

    localparam int unsigned WIDE_W = 32;

    typedef logic signed [WIDE_W-1:0] wide_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned stages_of(input int unsigned n);
        return $clog2(n);
    endfunction

    function automatic wide_t llr_max(input int unsigned w);
        return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    endfunction

    // Symmetric clamp; also maps the most negative code onto -max.
    function automatic wide_t saturate(input wide_t x, input int unsigned w);
        wide_t lim;
        lim = llr_max(w);
        if (x > lim) begin
            return lim;
        end
        if (x < -lim) begin
            return -lim;
        end
        return x;
    endfunction

    function automatic wide_t f_op(input wide_t a, input wide_t b);
        wide_t ma;
        wide_t mb;
        wide_t m;
        ma = (a < 0) ? -a : a;
        mb = (b < 0) ? -b : b;
        m  = (ma < mb) ? ma : mb;
        return ((a < 0) != (b < 0)) ? -m : m;
    endfunction

    function automatic wide_t g_op(input wide_t a, input wide_t b, input logic s);
        return s ? (b - a) : (b + a);
    endfunction

    function automatic int unsigned trailing_zeros(input logic [31:0] v);
        int unsigned n;
        logic        found;
        n     = 0;
        found = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (!found) begin
                if (v[k]) begin
                    found = 1'b1;
                end else begin
                    n = n + 1;
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/polar_sc_decoder_pe.sv
// One lane of the SC datapath: min-sum f or g node, result saturated to the LLR range.
module polar_pe
    import polar_pkg::*;
#(
    parameter int unsigned LLR_W = 8
) (
    input  logic signed [LLR_W-1:0] a_i,
    input  logic signed [LLR_W-1:0] b_i,
    input  logic                    s_i,
    input  logic                    g_i,
    output logic signed [LLR_W-1:0] y_o
);

    wide_t a_w;
    wide_t b_w;
    wide_t r_w;

    always_comb begin
        a_w = saturate(wide_t'(a_i), LLR_W);
        b_w = saturate(wide_t'(b_i), LLR_W);
        r_w = g_i ? saturate(g_op(a_w, b_w, s_i), LLR_W) : f_op(a_w, b_w);
        y_o = LLR_W'(r_w);
    end

endmodule

// File: rtl/polar_sc_decoder.sv
// Successive-cancellation polar decoder: one tree node per clock, depth-first, left child first.
// Stage s of llr_q holds the 2^s LLRs of the node currently being worked on at that depth.
module polar_sc_decoder
    import polar_pkg::*;
#(
    parameter int unsigned     BITS   = 4,
    parameter int unsigned     LLR_W  = 8,
    parameter logic [BITS-1:0] FROZEN = 4'b0011
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid_i,
    input  logic signed [LLR_W-1:0] llr_i [BITS],
    output logic                    busy_o,
    output logic                    out_valid_o,
    output logic [BITS-1:0]         u_hat_o,
    output logic [BITS-1:0]         x_hat_o
);

    localparam int unsigned STAGES = stages_of(BITS);
    localparam int unsigned LANES  = BITS / 2;
    localparam int unsigned LW     = STAGES;
    localparam int unsigned LEAF_W = STAGES + 1;
    localparam int unsigned STG_W  = $clog2(STAGES + 1);
    localparam int unsigned FINAL  = 2 * BITS - 2;
    localparam int unsigned CNT_W  = $clog2(FINAL + 1);

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [LEAF_W-1:0]       leaf_q;
    logic [STG_W-1:0]        stage_q;
    logic signed [LLR_W-1:0] llr_q [STAGES+1][BITS];
    logic [BITS-1:0]         ps_q  [STAGES+1];
    logic [BITS-1:0]         u_q;
    logic [BITS-1:0]         root_q;

    logic [STG_W-1:0]        src_stage;
    logic [LW-1:0]           hi_idx;
    logic [LEAF_W-1:0]       leaf_nxt;
    logic                    is_g;
    logic                    leaf_dec;
    logic                    chain;
    logic [BITS-1:0]         cur;
    logic [BITS-1:0]         mask;
    logic [BITS-1:0]         ps_d  [STAGES+1];
    logic [BITS-1:0]         root_d;
    logic [LANES-1:0]        lane_en;
    logic [LANES-1:0]        pe_s;
    logic signed [LLR_W-1:0] pe_a [LANES];
    logic signed [LLR_W-1:0] pe_b [LANES];
    logic signed [LLR_W-1:0] pe_y [LANES];

    // Operand routing, leaf decision and the partial-sum cascade for the current step.
    always_comb begin
        src_stage = stage_q + STG_W'(1);
        leaf_nxt  = leaf_q + LEAF_W'(1);
        is_g      = leaf_q[stage_q];
        hi_idx    = '0;
        for (int j = 0; j < LANES; j++) begin
            hi_idx     = LW'(j) + (LW'(1) << stage_q);
            pe_a[j]    = llr_q[src_stage][j];
            pe_b[j]    = llr_q[src_stage][hi_idx];
            pe_s[j]    = ps_q[stage_q][j];
            lane_en[j] = (j < (1 << stage_q));
        end
        leaf_dec = ~FROZEN[leaf_q[LW-1:0]] & pe_y[0][LLR_W-1];

        // A finished right child folds into its parent until a left child is reached.
        ps_d   = ps_q;
        root_d = root_q;
        cur    = '0;
        cur[0] = leaf_dec;
        chain  = 1'b1;
        mask   = '0;
        for (int s = 0; s < STAGES; s++) begin
            mask = BITS'((64'd1 << (1 << s)) - 64'd1);
            if (chain) begin
                if (!leaf_q[s]) begin
                    ps_d[s] = cur;
                    chain   = 1'b0;
                end else begin
                    cur = ((cur & mask) << (1 << s)) | ((cur ^ ps_q[s]) & mask);
                end
            end
        end
        if (chain) begin
            root_d = cur;
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        polar_pe #(
            .LLR_W(LLR_W)
        ) u_pe (
            .a_i(pe_a[j]),
            .b_i(pe_b[j]),
            .s_i(pe_s[j]),
            .g_i(is_g),
            .y_o(pe_y[j])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_o      <= 1'b0;
            out_valid_o <= 1'b0;
            u_hat_o     <= '0;
            x_hat_o     <= '0;
            cnt_q       <= '0;
            leaf_q      <= '0;
            stage_q     <= '0;
            u_q         <= '0;
            root_q      <= '0;
            for (int s = 0; s <= STAGES; s++) begin
                ps_q[s] <= '0;
                for (int j = 0; j < BITS; j++) begin
                    llr_q[s][j] <= '0;
                end
            end
        end else begin
            out_valid_o <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (in_valid_i) begin
                        state_q <= RUN;
                        busy_o  <= 1'b1;
                        cnt_q   <= '0;
                        leaf_q  <= '0;
                        stage_q <= STG_W'(STAGES - 1);
                        u_q     <= '0;
                        for (int j = 0; j < BITS; j++) begin
                            llr_q[STAGES][j] <= llr_i[j];
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    if (cnt_q == CNT_W'(FINAL)) begin
                        state_q     <= DONE;
                        busy_o      <= 1'b0;
                        out_valid_o <= 1'b1;
                        u_hat_o     <= u_q;
                        x_hat_o     <= root_q;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        for (int j = 0; j < LANES; j++) begin
                            if (lane_en[j]) begin
                                llr_q[stage_q][j] <= pe_y[j];
                            end
                        end
                        // Leaf step: decide, fold partial sums, jump to the next leaf's branch point.
                        if (stage_q == '0) begin
                            u_q[leaf_q[LW-1:0]] <= leaf_dec;
                            ps_q                <= ps_d;
                            root_q              <= root_d;
                            leaf_q              <= leaf_nxt;
                            stage_q             <= STG_W'(trailing_zeros(32'(leaf_nxt)));
                        end else begin
                            stage_q <= stage_q - STG_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_polar_sc_decoder.sv
// Directed bench for polar_sc_decoder (N=4, LLR_W=8, FROZEN=4'b0011) with a result scoreboard.
module tb_polar_sc_decoder;

    localparam int unsigned BITS   = 4;
    localparam int unsigned LLR_W  = 8;
    localparam logic [3:0]  FROZEN = 4'b0011;

    typedef struct packed {
        logic [3:0] u;
        logic [3:0] x;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic signed [LLR_W-1:0] llr [BITS];
    logic                    busy;
    logic                    out_valid;
    logic [BITS-1:0]         u_hat;
    logic [BITS-1:0]         x_hat;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    exp_t sb[$];

    polar_sc_decoder #(
        .BITS(BITS),
        .LLR_W(LLR_W),
        .FROZEN(FROZEN)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid_i(in_valid),
        .llr_i(llr),
        .busy_o(busy),
        .out_valid_o(out_valid),
        .u_hat_o(u_hat),
        .x_hat_o(x_hat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sat(input int v);
        if (v > 127) return 127;
        if (v < -127) return -127;
        return v;
    endfunction

    function automatic int fm(input int a, input int b);
        int ma;
        int mb;
        int m;
        ma = (a < 0) ? -a : a;
        mb = (b < 0) ? -b : b;
        m  = (ma < mb) ? ma : mb;
        return ((a < 0) != (b < 0)) ? -m : m;
    endfunction

    function automatic int gm(input int a, input int b, input logic s);
        return sat(s ? (b - a) : (b + a));
    endfunction

    function automatic logic [3:0] enc(input logic [3:0] u);
        logic [3:0] x;
        x = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if ((j & i) == i) x[i] = x[i] ^ u[j];
        return x;
    endfunction

    // Closed-form N=4 SC decoder.
    function automatic logic [3:0] model_u(input int y0, input int y1, input int y2, input int y3);
        int c0, c1, c2, c3, l0, l1, r0, r1;
        logic [3:0] u;
        c0 = sat(y0); c1 = sat(y1); c2 = sat(y2); c3 = sat(y3);
        l0 = fm(c0, c2);
        l1 = fm(c1, c3);
        u[0] = FROZEN[0] ? 1'b0 : (fm(l0, l1) < 0);
        u[1] = FROZEN[1] ? 1'b0 : (gm(l0, l1, u[0]) < 0);
        r0 = gm(c0, c2, u[0] ^ u[1]);
        r1 = gm(c1, c3, u[1]);
        u[2] = FROZEN[2] ? 1'b0 : (fm(r0, r1) < 0);
        u[3] = FROZEN[3] ? 1'b0 : (gm(r0, r1, u[2]) < 0);
        return u;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the following posedge is the accepting edge.
    task automatic drive(input int y0, input int y1, input int y2, input int y3, input bit push);
        exp_t e;
        llr[0] = LLR_W'(y0);
        llr[1] = LLR_W'(y1);
        llr[2] = LLR_W'(y2);
        llr[3] = LLR_W'(y3);
        in_valid = 1'b1;
        if (push) begin
            e.u = model_u(y0, y1, y2, y3);
            e.x = enc(e.u);
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    // Returns at the negedge where out_valid is high, so the caller may chain a decode.
    task automatic collect(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        if (out_valid) begin
            check({tag, "_latency"}, 32'(cyc - acc_cyc), 32'd7);
            check({tag, "_busy"}, 32'(busy), 32'd0);
            check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({tag, "_u"}, 32'(u_hat), 32'(e.u));
                check({tag, "_x"}, 32'(x_hat), 32'(e.x));
            end
        end
    endtask

    task automatic count_pulses(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
    endtask

    initial begin
        int         pulses;
        logic [3:0] uu;
        logic [3:0] xx;
        for (int i = 0; i < 4; i++) llr[i] = '0;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_u", 32'(u_hat), 32'd0);
        check("rst_x", 32'(x_hat), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        drive(20, -20, 20, -20, 1'b1);
        check("clean_busy", 32'(busy), 32'd1);
        collect("clean");
        check("clean_u_const", 32'(u_hat), 32'b1100);
        check("clean_x_const", 32'(x_hat), 32'b1010);
        repeat (2) @(negedge clk);

        drive(20, -20, 20, 5, 1'b1);
        collect("errcorr");
        check("errcorr_u_const", 32'(u_hat), 32'b1100);
        check("errcorr_x_const", 32'(x_hat), 32'b1010);
        repeat (2) @(negedge clk);

        drive(100, -100, 100, -100, 1'b1);
        collect("sat");
        check("sat_u_const", 32'(u_hat), 32'b1100);
        repeat (2) @(negedge clk);

        drive(-128, -100, 100, -100, 1'b1);
        collect("minneg");
        check("minneg_u_const", 32'(u_hat), 32'b1000);
        check("minneg_x_const", 32'(x_hat), 32'b1111);
        repeat (2) @(negedge clk);

        drive(-50, -50, 50, 50, 1'b1);
        collect("frozen");
        check("frozen_u_const", 32'(u_hat), 32'b0000);
        repeat (2) @(negedge clk);

        // in_valid during RUN must be ignored
        drive(20, -20, 20, -20, 1'b1);
        @(negedge clk);
        llr[0] = -8'sd50; llr[1] = -8'sd50; llr[2] = 8'sd50; llr[3] = 8'sd50;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        collect("ignore");
        count_pulses(12, pulses);
        check("ignore_no_extra_pulse", 32'(pulses), 32'd0);

        // Back-to-back: second decode accepted in the out_valid cycle
        drive(20, -20, 20, 5, 1'b1);
        collect("b2b_a");
        drive(-50, -50, 50, 50, 1'b1);
        collect("b2b_b");
        repeat (2) @(negedge clk);

        // Reset mid-decode at schedule step 3
        drive(20, -20, 20, -20, 1'b1);
        collect("pre_reset");
        repeat (2) @(negedge clk);
        drive(100, -100, 100, -100, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_u", 32'(u_hat), 32'd0);
        check("abort_x", 32'(x_hat), 32'd0);
        rst_n = 1'b1;
        count_pulses(12, pulses);
        check("abort_no_pulse", 32'(pulses), 32'd0);
        drive(20, -20, 20, 5, 1'b1);
        collect("post_reset");
        repeat (2) @(negedge clk);

        // All 16 u vectors through the encoder, mapped to +/-20
        for (int k = 0; k < 16; k++) begin
            uu = 4'(k);
            xx = enc(uu);
            drive(xx[0] ? -20 : 20, xx[1] ? -20 : 20, xx[2] ? -20 : 20, xx[3] ? -20 : 20, 1'b1);
            collect("exh");
            if (uu[1:0] == 2'b00) begin
                check("exh_info_u", 32'(u_hat), 32'(uu));
                check("exh_info_x", 32'(x_hat), 32'(xx));
            end
            @(negedge clk);
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
